ffe_serial_mac: RTL and testbench
=================================

Name: ffe_serial_mac

Overview:
Time-multiplexed multiply-accumulate stage directly downstream of the FFE tap-delay registers. On each start it snapshots the tap-register outputs and the coefficient set, then multiplies and accumulates one tap per cycle. It rounds and saturates the sum to a WIDTH-bit equalizer output sample and flags completion with a one-cycle done pulse. A clear input aborts the current operation and zeroes the output, mirroring the delete control on the tap registers.

Parameters:
WIDTH, 12, signed sample width of each tap and of output y
TAPS, 4, number of FFE taps (>=2)
COEF_W, 12, signed coefficient width, Q1.(COEF_W-1) format
ACC_W, 26, accumulator width; must be >= WIDTH+COEF_W+clog2(TAPS)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request one output computation; sampled only in IDLE
clear  input  1  synchronous abort/zero (equivalent of tap-register delete)
taps_flat  input  TAPS*WIDTH  tap-register outputs, tap k at bits [k*WIDTH +: WIDTH], signed
coef_flat  input  TAPS*COEF_W  coefficients, coef k at bits [k*COEF_W +: COEF_W], signed
busy  output  1  high while a computation is in progress
done  output  1  one-cycle pulse: y updated this cycle
y  output  WIDTH  rounded, saturated filter output, signed

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset (rst=1 at a clk edge): state=IDLE, acc=0, index=0, busy=0, done=0, y=0. Tap/coef snapshot registers are also zeroed. rst overrides all other inputs, including mid-operation.
- clear=1 (rst=0): same effect as reset, in any state. clear has priority over start.
- States: IDLE, MAC, OUT.
- IDLE: when start=1, latch taps_flat and coef_flat into snapshot registers, set acc=0 and index=0, then go to MAC. Inputs may change freely after the start edge.
- MAC: each cycle, acc += sext(tap[index]) * sext(coef[index]), with a full-precision signed product and ACC_W-bit signed accumulation.
  - index increments each cycle.
  - After the cycle with index=TAPS-1, go to OUT.
  - MAC lasts exactly TAPS cycles.
- OUT: compute r = (acc + 2^(COEF_W-2)) >>> (COEF_W-1), an arithmetic shift (round-half toward +inf).
  - Saturate r to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Register the result into y, pulse done=1 for the next cycle, and go to IDLE.
- Timing: start sampled at edge T. busy=1 during cycles T+1 through T+TAPS+1. y and done are valid at cycle T+TAPS+2; done lasts one cycle. Latency from start to done is TAPS+2 cycles.
- y holds its value between computations. It changes only at done, reset or clear.
- start while busy=1: ignored, with no queueing.
- start in the cycle where done=1: accepted, because the FSM is already in IDLE. Back-to-back throughput is one result per TAPS+2 cycles.
- No overflow is possible inside acc, given the ACC_W constraint. Saturation occurs only at the output stage.

Test Plan (WIDTH=12, TAPS=4, COEF_W=12):
1. taps all 100, coef={1024,0,0,0}, pulse start at T -> busy high T+1..T+5; done=1 and y=50 at T+6 only.
2. tap0=3 with coef0=1024 (others 0) -> y=2. tap0=-3 -> y=-1, confirming round-half toward +inf.
3. taps all 2047, coefs all 1024 -> y=2047 (positive saturation). Taps all -2048 -> y=-2048 (negative saturation).
4. start re-pulsed at T+2 while busy -> ignored, single done at T+6. Then start during the done cycle -> second done 6 cycles later. Change taps_flat right after start -> result uses snapshot values.
5. clear=1 at T+3 mid-MAC -> next cycle busy=0, y=0, no done pulse. A following start computes correctly from acc=0.
6. rst=1 during MAC, and again during OUT -> busy=0, done=0, y=0 next cycle. A start held high across the reset deassertion is accepted on the first non-reset edge.

Source files
------------

// File: rtl/ffe_serial_mac_if.sv
// ffe_serial_mac_if: handshake and data bundle for the FFE serial MAC stage.
//
// Signals:
//   start     - request one output computation (master -> slave)
//   clear     - synchronous abort / zero output (master -> slave)
//   taps_flat - tap-register outputs, tap k at [k*WIDTH +: WIDTH], signed
//   coef_flat - coefficients, coef k at [k*COEF_W +: COEF_W], signed Q1.(COEF_W-1)
//   busy      - computation in progress (slave -> master)
//   done      - one-cycle pulse, y updated this cycle (slave -> master)
//   y         - rounded, saturated equalizer output sample (slave -> master)
interface ffe_serial_mac_if #(
    parameter int WIDTH  = 12,
    parameter int TAPS   = 4,
    parameter int COEF_W = 12
);
    logic                     start;
    logic                     clear;
    logic [TAPS*WIDTH-1:0]    taps_flat;
    logic [TAPS*COEF_W-1:0]   coef_flat;
    logic                     busy;
    logic                     done;
    logic signed [WIDTH-1:0]  y;

    modport master (
        output start, clear, taps_flat, coef_flat,
        input  busy, done, y
    );

    modport slave (
        input  start, clear, taps_flat, coef_flat,
        output busy, done, y
    );
endinterface

// File: rtl/ffe_serial_mac.sv
// ffe_serial_mac: time-multiplexed multiply-accumulate stage fed by the FFE
// tap-delay registers. A start snapshots taps and coefficients, then one
// tap product is accumulated per cycle. The sum is rounded (half toward
// +inf), saturated to WIDTH bits and presented on y with a one-cycle done.
//
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous reset, active-high
//   bus - ffe_serial_mac_if slave: start, clear, taps_flat, coef_flat in;
//         busy, done, y out
module ffe_serial_mac #(
    parameter int WIDTH  = 12,
    parameter int TAPS   = 4,
    parameter int COEF_W = 12,
    parameter int ACC_W  = 26
) (
    input  logic              clk,
    input  logic              rst,
    ffe_serial_mac_if.slave   bus
);
    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = WIDTH + COEF_W;

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(TAPS - 1);
    // Rounding and saturation run one bit wider than acc so the rounding
    // offset can never wrap, regardless of how ACC_W is chosen.
    localparam logic signed [ACC_W:0] HALF    = (ACC_W + 1)'(2 ** (COEF_W - 2));
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [WIDTH-1:0]  tap_s  [TAPS];
    logic signed [COEF_W-1:0] coef_s [TAPS];
    logic                     busy_r;
    logic                     done_r;
    logic signed [WIDTH-1:0]  y_r;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W:0]    acc_ext;
    logic signed [ACC_W:0]    rnd_sum;
    logic signed [ACC_W:0]    shifted;
    logic signed [WIDTH-1:0]  y_next;

    always_comb begin
        prod     = tap_s[idx] * coef_s[idx];
        prod_ext = prod;
        acc_ext  = acc;
        rnd_sum  = acc_ext + HALF;
        shifted  = rnd_sum >>> (COEF_W - 1);
        y_next   = shifted[WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            y_next = SAT_MAX[WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            y_next = SAT_MIN[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        // done is a pulse: low unless the OUT branch raises it below.
        done_r <= 1'b0;
        if (rst || bus.clear) begin
            state  <= IDLE;
            idx    <= '0;
            acc    <= '0;
            busy_r <= 1'b0;
            y_r    <= '0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                tap_s[k]  <= '0;
                coef_s[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int unsigned k = 0; k < TAPS; k++) begin
                            tap_s[k]  <= bus.taps_flat[k*WIDTH +: WIDTH];
                            coef_s[k] <= bus.coef_flat[k*COEF_W +: COEF_W];
                        end
                        acc    <= '0;
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    y_r    <= y_next;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.y    = y_r;
endmodule

// File: tb/tb_ffe_serial_mac.sv
// tb_ffe_serial_mac: randomized and directed stimulus for ffe_serial_mac.
// Expected outputs come from a plain-arithmetic reference model and are
// queued with the cycle on which done is due; a monitor pops and compares.
module tb_ffe_serial_mac;
    localparam int WIDTH  = 12;
    localparam int TAPS   = 4;
    localparam int COEF_W = 12;
    localparam int ACC_W  = 26;
    localparam int TW     = TAPS * WIDTH;
    localparam int CW     = TAPS * COEF_W;
    localparam int LAT    = TAPS + 2;

    typedef struct {
        int y;
        int cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    ffe_serial_mac_if #(.WIDTH(WIDTH), .TAPS(TAPS), .COEF_W(COEF_W)) bus ();

    ffe_serial_mac #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .COEF_W(COEF_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer dot product, then floor((s + 2^(C-2)) / 2^(C-1)),
    // then clamp to the signed WIDTH-bit range.
    function automatic int model(input logic [TW-1:0] t, input logic [CW-1:0] c);
        longint s, tv, cv, num, den, q, lo, hi;
        s = 0;
        for (int k = 0; k < TAPS; k++) begin
            tv = $signed(t[k*WIDTH +: WIDTH]);
            cv = $signed(c[k*COEF_W +: COEF_W]);
            s += tv * cv;
        end
        den = longint'(1) << (COEF_W - 1);
        num = s + (longint'(1) << (COEF_W - 2));
        q = num / den;
        if (num < 0 && q * den != num) q = q - 1;
        hi = (longint'(1) << (WIDTH - 1)) - 1;
        lo = -(longint'(1) << (WIDTH - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return int'(q);
    endfunction

    function automatic logic [TW-1:0] taps_all(input int v);
        logic [TW-1:0] r;
        for (int k = 0; k < TAPS; k++) r[k*WIDTH +: WIDTH] = WIDTH'(v);
        return r;
    endfunction

    function automatic logic [CW-1:0] coef_all(input int v);
        logic [CW-1:0] r;
        for (int k = 0; k < TAPS; k++) r[k*COEF_W +: COEF_W] = COEF_W'(v);
        return r;
    endfunction

    function automatic logic [CW-1:0] coef_first(input int v);
        logic [CW-1:0] r;
        r = '0;
        r[COEF_W-1:0] = COEF_W'(v);
        return r;
    endfunction

    function automatic logic [TW-1:0] rand_taps();
        logic [TW-1:0] r;
        for (int k = 0; k < TAPS; k++) begin
            case ($urandom_range(0, 5))
                0:       r[k*WIDTH +: WIDTH] = WIDTH'(2 ** (WIDTH - 1) - 1);
                1:       r[k*WIDTH +: WIDTH] = WIDTH'(-(2 ** (WIDTH - 1)));
                default: r[k*WIDTH +: WIDTH] = WIDTH'($urandom);
            endcase
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] rand_coef();
        logic [CW-1:0] r;
        for (int k = 0; k < TAPS; k++) begin
            case ($urandom_range(0, 5))
                0:       r[k*COEF_W +: COEF_W] = COEF_W'(2 ** (COEF_W - 1) - 1);
                1:       r[k*COEF_W +: COEF_W] = COEF_W'(-(2 ** (COEF_W - 1)));
                default: r[k*COEF_W +: COEF_W] = COEF_W'($urandom);
            endcase
        end
        return r;
    endfunction

    // Called at a negedge: presents start for one edge, queues the expected
    // result, then scrambles the inputs so only the snapshot can be used.
    task automatic issue(input logic [TW-1:0] t, input logic [CW-1:0] c);
        exp_t e;
        bus.taps_flat = t;
        bus.coef_flat = c;
        bus.start     = 1'b1;
        e.y   = model(t, c);
        e.cyc = cyc + LAT;
        sb.push_back(e);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.taps_flat = rand_taps();
        bus.coef_flat = rand_coef();
    endtask

    task automatic known_result();
        issue(taps_all(100), coef_first(1024));
        repeat (LAT) @(negedge clk);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_y"}, int'(bus.y), 0);
    endtask

    // Monitor: every done must match the head of the scoreboard, both in
    // value and in the cycle it was due; a due entry without done is missed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: y=%0d with empty scoreboard (cycle %0d)",
                             bus.y, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("y", int'(bus.y), e.y);
                    chk("done_cycle", cyc, e.cyc);
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                e = sb.pop_front();
                chk("missing_done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.clear     = 1'b0;
        bus.taps_flat = '0;
        bus.coef_flat = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Busy window and latency: busy over the TAPS+1 cycles after the start edge.
        n = cyc;
        issue(taps_all(100), coef_first(1024));
        for (int i = 1; i <= TAPS + 1; i++) begin
            chk("busy_window", int'(bus.busy), 1);
            @(negedge clk);
        end
        chk("busy_after", int'(bus.busy), 0);
        chk("latency_cycle", cyc - n, LAT);

        // Round-half toward +inf on both signs.
        issue(taps_all(3), coef_first(1024));
        repeat (LAT) @(negedge clk);
        issue(taps_all(-3), coef_first(1024));
        repeat (LAT) @(negedge clk);

        // Saturation in both directions.
        issue(taps_all(2047), coef_all(1024));
        repeat (LAT) @(negedge clk);
        issue(taps_all(-2048), coef_all(1024));
        repeat (LAT) @(negedge clk);

        // Start re-pulsed while busy is ignored; start in the done cycle is taken.
        issue(taps_all(100), coef_first(1024));
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (LAT - 3) @(negedge clk);
        chk("done_at_reissue", int'(bus.done), 1);
        issue(rand_taps(), rand_coef());
        repeat (LAT) @(negedge clk);

        // Clear mid-MAC: no done, output zeroed, following start is clean.
        known_result();
        issue(rand_taps(), rand_coef());
        @(negedge clk);
        bus.clear = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        bus.clear = 1'b0;
        check_idle_zero("clear");
        issue(taps_all(3), coef_first(1024));
        repeat (LAT) @(negedge clk);

        // Reset during MAC.
        known_result();
        issue(rand_taps(), rand_coef());
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("rst_mac");

        // Reset during OUT.
        known_result();
        issue(rand_taps(), rand_coef());
        repeat (TAPS) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("rst_out");

        // Start held high across reset deassertion is taken on the first free edge.
        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(taps_all(-3), coef_first(1024));
        repeat (LAT) @(negedge clk);

        // Randomized traffic, sometimes back-to-back in the done cycle.
        for (int i = 0; i < 40; i++) begin
            issue(rand_taps(), rand_coef());
            repeat (LAT - 1) @(negedge clk);
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        repeat (LAT + 4) @(negedge clk);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
